// File: rtl/mem_copy_engine.sv
// Block-copy initiator for the 256x32 memory controller: primes one read, then streams one word per cycle.
// Optional XOR checksum of the copied words is enabled with `define MEM_COPY_CHECKSUM_EN.
module mem_copy_engine #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] mem_read_address,
    output logic              mem_read_enable,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic              mem_write_enable,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   words_done
`ifdef MEM_COPY_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [1:0] {IDLE, READ0, STREAM, DONE} state_t;

    localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   src_q, src_d, dst_q, dst_d;
    logic [ADDR_W:0]     len_q, len_d, rcnt_q, rcnt_d, wcnt_q, wcnt_d;
    logic [ADDR_W:0]     words_done_q, words_done_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
    logic                rd_en_q, rd_en_d, wr_en_q, wr_en_d;
    logic                busy_q, busy_d, done_q, done_d;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [DATA_W-1:0]   checksum_q, checksum_d;
`endif

    // Write data is the controller's registered read data, forced to zero when no write is issued.
    assign mem_data_in = wr_en_q ? mem_rdata : '0;

    always_comb begin
        // NOTE: every variable gets a default up front so no path leaves it unassigned (no latches).
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        len_d        = len_q;
        rcnt_d       = rcnt_q;
        wcnt_d       = wcnt_q;
        words_done_d = words_done_q;
`ifdef MEM_COPY_CHECKSUM_EN
        checksum_d   = checksum_q;
`endif

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d        = src_addr;
                    dst_d        = dst_addr;
                    len_d        = (len > MAX_LEN) ? MAX_LEN : len;
                    rcnt_d       = '0;
                    wcnt_d       = '0;
                    words_done_d = '0;
`ifdef MEM_COPY_CHECKSUM_EN
                    checksum_d   = '0;
`endif
                    state_d      = (len == '0) ? DONE : READ0;
                end
            end
            READ0: begin
                rcnt_d  = rcnt_q + 1'b1;
                state_d = STREAM;
            end
            STREAM: begin
                wcnt_d       = wcnt_q + 1'b1;
                words_done_d = words_done_q + 1'b1;
`ifdef MEM_COPY_CHECKSUM_EN
                checksum_d   = checksum_q ^ mem_data_in;
`endif
                if (rcnt_q < len_q) rcnt_d = rcnt_q + 1'b1;
                if (wcnt_q == len_q - 1'b1) state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from next state so they register in step with the state flop.
        rd_en_d   = (state_d == READ0) || ((state_d == STREAM) && (rcnt_d < len_d));
        rd_addr_d = rd_en_d ? src_d + rcnt_d[ADDR_W-1:0] : '0;
        wr_en_d   = (state_d == STREAM);
        wr_addr_d = wr_en_d ? dst_d + wcnt_d[ADDR_W-1:0] : '0;
        busy_d    = (state_d == READ0) || (state_d == STREAM);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            len_q        <= '0;
            rcnt_q       <= '0;
            wcnt_q       <= '0;
            words_done_q <= '0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef MEM_COPY_CHECKSUM_EN
            checksum_q   <= '0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            len_q        <= len_d;
            rcnt_q       <= rcnt_d;
            wcnt_q       <= wcnt_d;
            words_done_q <= words_done_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef MEM_COPY_CHECKSUM_EN
            checksum_q   <= checksum_d;
`endif
        end
    end

    assign mem_read_address  = rd_addr_q;
    assign mem_read_enable   = rd_en_q;
    assign mem_write_address = wr_addr_q;
    assign mem_write_enable  = wr_en_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign words_done        = words_done_q;
`ifdef MEM_COPY_CHECKSUM_EN
    assign checksum          = checksum_q;
`endif

endmodule

// File: tb/tb_mem_copy_engine.sv
// Bench for mem_copy_engine wired to a behavioural 256x32 controller model; expected reads, writes
// and done events are queued by the stimulus and consumed by an independent monitor.
module tb_mem_copy_engine;

    localparam int AW = 8;
    localparam int DW = 32;

    logic          clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start;
    logic [AW-1:0] src_addr, dst_addr;
    logic [AW:0]   len;
    logic [AW-1:0] mem_read_address, mem_write_address;
    logic          mem_read_enable, mem_write_enable;
    logic [DW-1:0] mem_data_in, mem_rdata;
    logic          busy, done;
    logic [AW:0]   words_done;
`ifdef MEM_COPY_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    mem_copy_engine #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .src_addr          (src_addr),
        .dst_addr          (dst_addr),
        .len               (len),
        .mem_read_address  (mem_read_address),
        .mem_read_enable   (mem_read_enable),
        .mem_write_address (mem_write_address),
        .mem_write_enable  (mem_write_enable),
        .mem_data_in       (mem_data_in),
        .mem_rdata         (mem_rdata),
        .busy              (busy),
        .done              (done),
        .words_done        (words_done)
`ifdef MEM_COPY_CHECKSUM_EN
        ,
        .checksum          (checksum)
`endif
    );

    // Controller model: registered read data, read returns the pre-write value on a same-cycle collision.
    logic [DW-1:0] mem   [256];
    logic [DW-1:0] model [256];
    logic          mem_clear, tb_we;
    logic [AW-1:0] tb_wa;
    logic [DW-1:0] tb_wd;

    always @(posedge clk) begin
        if (mem_read_enable) mem_rdata <= mem[mem_read_address];
        if (mem_clear) begin
            for (int i = 0; i < 256; i++) mem[i] <= '0;
        end else if (mem_write_enable) begin
            mem[mem_write_address] <= mem_data_in;
        end else if (tb_we) begin
            mem[tb_wa] <= tb_wd;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_event(input string name, input logic [63:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got %0h expected none", name, act);
    endtask

    typedef struct packed { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
    typedef struct packed { logic [AW:0] words; logic [DW-1:0] sum; } dn_t;

    wr_t           wr_q[$];
    logic [AW-1:0] rd_q[$];
    dn_t           dn_q[$];
    int            rd_cnt = 0, wr_cnt = 0, busy_cnt = 0, done_cnt = 0;
    wr_t           mon_wr;
    dn_t           mon_dn;

    always @(negedge clk) begin
        if (!reset) begin
            if (mem_read_enable) begin
                rd_cnt++;
                if (rd_q.size() == 0) fail_event("read_unexpected", 64'(mem_read_address));
                else check("read_addr", 64'(mem_read_address), 64'(rd_q.pop_front()));
            end
            if (mem_write_enable) begin
                wr_cnt++;
                if (wr_q.size() == 0) fail_event("write_unexpected", 64'(mem_write_address));
                else begin
                    mon_wr = wr_q.pop_front();
                    check("write_addr", 64'(mem_write_address), 64'(mon_wr.addr));
                    check("write_data", 64'(mem_data_in), 64'(mon_wr.data));
                    model[mon_wr.addr] = mon_wr.data;
                end
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (dn_q.size() == 0) fail_event("done_unexpected", 64'(words_done));
                else begin
                    mon_dn = dn_q.pop_front();
                    check("done_words", 64'(words_done), 64'(mon_dn.words));
`ifdef MEM_COPY_CHECKSUM_EN
                    check("done_checksum", 64'(checksum), 64'(mon_dn.sum));
`endif
                end
            end
        end
    end

    // Predicts the transfer: read i coincides with write i-1, so only writes up to i-2 are visible to it.
    task automatic expect_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n_in);
        logic [DW-1:0] tmp [256];
        logic [DW-1:0] dat [256];
        logic [DW-1:0] sum;
        logic [AW-1:0] a;
        wr_t           w;
        dn_t           e;
        int            n;
        n   = (n_in > 256) ? 256 : n_in;
        sum = '0;
        for (int i = 0; i < 256; i++) tmp[i] = model[i];
        for (int i = 0; i < n; i++) begin
            if (i >= 2) begin
                a      = AW'(int'(d) + i - 2);
                tmp[a] = dat[i-2];
            end
            a      = AW'(int'(s) + i);
            dat[i] = tmp[a];
            rd_q.push_back(a);
            w.addr = AW'(int'(d) + i);
            w.data = dat[i];
            wr_q.push_back(w);
            sum    = sum ^ dat[i];
        end
        e.words = (AW+1)'(n);
        e.sum   = sum;
        dn_q.push_back(e);
    endtask

    task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] v);
        @(negedge clk);
        tb_we = 1'b1; tb_wa = a; tb_wd = v;
        model[a] = v;
        @(negedge clk);
        tb_we = 1'b0;
    endtask

    task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW:0] n,
                            input int exp_cyc, input bit pulse_again);
        int cyc;
        expect_copy(s, d, int'(n));
        @(negedge clk);
        start = 1'b1; src_addr = s; dst_addr = d; len = n;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 600) begin
            start = pulse_again && (cyc == 3);
            if (start) begin
                src_addr = 8'h55; dst_addr = 8'hAA; len = 9'd7;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check("done_cycle", 64'(cyc), 64'(exp_cyc));
        @(negedge clk);
        check("words_done_hold", 64'(words_done), 64'((n > 9'd256) ? 9'd256 : n));
        check("idle_not_busy", 64'(busy), 64'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_re"},   64'(mem_read_enable),   64'd0);
        check({tag, "_we"},   64'(mem_write_enable),  64'd0);
        check({tag, "_ra"},   64'(mem_read_address),  64'd0);
        check({tag, "_wa"},   64'(mem_write_address), 64'd0);
        check({tag, "_din"},  64'(mem_data_in),       64'd0);
        check({tag, "_busy"}, 64'(busy),              64'd0);
        check({tag, "_done"}, 64'(done),              64'd0);
        check({tag, "_wd"},   64'(words_done),        64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int b_rd, b_wr, b_busy, b_done;
        reset = 1'b1; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        tb_we = 1'b0; tb_wa = '0; tb_wd = '0; mem_clear = 1'b1;
        for (int i = 0; i < 256; i++) model[i] = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        mem_clear = 1'b0;
        reset     = 1'b0;

        // Basic four-word copy.
        for (int i = 0; i < 4; i++) poke(AW'(10 + i), 32'hA0A0_0000 + DW'(i));
        run_copy(8'd10, 8'd80, 9'd4, 6, 1'b0);
        check("t1_mem80", 64'(mem[80]), 64'hA0A0_0000);
        check("t1_mem81", 64'(mem[81]), 64'hA0A0_0001);
        check("t1_mem82", 64'(mem[82]), 64'hA0A0_0002);
        check("t1_mem83", 64'(mem[83]), 64'hA0A0_0003);

        // Zero-length transfer touches no memory and never raises busy.
        b_rd = rd_cnt; b_wr = wr_cnt; b_busy = busy_cnt;
        run_copy(8'd0, 8'd0, 9'd0, 1, 1'b0);
        check("t2_reads",  64'(rd_cnt - b_rd),     64'd0);
        check("t2_writes", 64'(wr_cnt - b_wr),     64'd0);
        check("t2_busy",   64'(busy_cnt - b_busy), 64'd0);

        // Source address wraps past 0xFF.
        poke(8'hFE, 32'd1); poke(8'hFF, 32'd2); poke(8'h00, 32'd3); poke(8'h01, 32'd4);
        run_copy(8'hFE, 8'h02, 9'd4, 6, 1'b0);
        check("t3_mem02", 64'(mem[2]), 64'd1);
        check("t3_mem03", 64'(mem[3]), 64'd2);
        check("t3_mem04", 64'(mem[4]), 64'd3);
        check("t3_mem05", 64'(mem[5]), 64'd4);

        // Forward overlap with a stray start during streaming.
        poke(8'h10, 32'd1); poke(8'h11, 32'd2); poke(8'h12, 32'd3);
        b_done = done_cnt;
        run_copy(8'h10, 8'h11, 9'd3, 5, 1'b1);
        repeat (4) @(negedge clk);
        check("t4_one_done", 64'(done_cnt - b_done), 64'd1);
        check("t4_mem11", 64'(mem[8'h11]), 64'd1);
        check("t4_mem12", 64'(mem[8'h12]), 64'd2);
        check("t4_mem13", 64'(mem[8'h13]), 64'd3);

        // Reset in cycle 3 of an eight-word copy, then a clean rerun.
        for (int i = 0; i < 8; i++) poke(AW'(8'h30 + i), 32'hC0DE_0000 + DW'(i));
        expect_copy(8'h30, 8'h90, 8);
        @(negedge clk);
        start = 1'b1; src_addr = 8'h30; dst_addr = 8'h90; len = 9'd8;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1 check_all_zero("midreset");
        check("t5_reads_left",  64'(rd_q.size()), 64'd6);
        check("t5_writes_left", 64'(wr_q.size()), 64'd7);
        rd_q.delete(); wr_q.delete(); dn_q.delete();
        @(negedge clk);
        reset = 1'b0;
        run_copy(8'h30, 8'h90, 9'd8, 10, 1'b0);
        check("t5_mem97", 64'(mem[8'h97]), 64'hC0DE_0007);

        // Oversized length is clamped to the full address space.
        run_copy(8'h00, 8'h80, 9'd300, 258, 1'b0);

        // Checksum vector.
        poke(8'h40, 32'h0F0F_0F0F); poke(8'h41, 32'hFF00_FF00); poke(8'h42, 32'h1234_5678);
        run_copy(8'h40, 8'h60, 9'd3, 5, 1'b0);
`ifdef MEM_COPY_CHECKSUM_EN
        check("t6_checksum", 64'(checksum), 64'hE23B_A677);
`endif
        check("t6_mem62", 64'(mem[8'h62]), 64'h1234_5678);

        check("end_reads_left",  64'(rd_q.size()), 64'd0);
        check("end_writes_left", 64'(wr_q.size()), 64'd0);
        check("end_dones_left",  64'(dn_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
